// File: rtl/e_mdu_if.sv
// ---------------------------------------------------------------------------
// e_mdu_if : operand, control and result bundle for the E-stage MDU.
//   start     : E-stage MDU instruction valid this cycle
//   MDU_op    : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//               7 MADD, 8 MSUB (last two only with MDU_MADD_EN)
//   A, B      : forwarded rs / rt values
//   HILO_sel  : 0 reads LO, 1 reads HI on HILO_out
//   busy      : multi-cycle operation in flight
//   HI, LO    : architectural HI/LO
//   HILO_out  : committed HI or LO, picked by HILO_sel
// master = pipeline side driving the unit, slave = the MDU itself.
// ---------------------------------------------------------------------------
interface e_mdu_if;
  logic        start;
  logic [3:0]  MDU_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HILO_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] HILO_out;

  modport master (
    output start, MDU_op, A, B, HILO_sel,
    input  busy, HI, LO, HILO_out
  );

  modport slave (
    input  start, MDU_op, A, B, HILO_sel,
    output busy, HI, LO, HILO_out
  );
endinterface

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit with the HI/LO register pair.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high; aborts any operation in flight
//   mdu    : e_mdu_if.slave (start/MDU_op/A/B/HILO_sel in,
//            busy/HI/LO/HILO_out out)
// MULT/MULTU/DIV/DIVU compute the 64-bit result at issue and hold it as a
// pending value; it is committed to HI/LO after a fixed latency
// (MULT_CYCLES / DIV_CYCLES, 1..255) while busy is reported. MTHI/MTLO
// write in a single cycle. Starts while busy are ignored.
// Optional feature macro: MDU_MADD_EN adds MADD (7) and MSUB (8).
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] phi_q,   phi_d;   // pending HI
  logic [31:0] plo_q,   plo_d;   // pending LO
  logic        pwr_q,   pwr_d;   // pending result is to be committed

  // -------------------------------------------------------------------------
  // Datapath, evaluated from the current operands every cycle
  // -------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
  assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

  // Signed division runs on magnitudes so that 0x80000000 / -1 needs no
  // special case: |0x80000000| is representable as unsigned, and the
  // re-signed quotient wraps back to 0x80000000. A zero divisor is replaced
  // by 1 only to keep the dividers defined; that result is never committed.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, sdiv, udiv;
  logic [31:0] mq, mr, sq, sr, uq, ur;

  always_comb begin
    a_neg  = mdu.A[31];
    b_neg  = mdu.B[31];
    b_zero = (mdu.B == 32'd0);
    a_mag  = a_neg ? (32'd0 - mdu.A) : mdu.A;
    b_mag  = b_neg ? (32'd0 - mdu.B) : mdu.B;
    sdiv   = b_zero ? 32'd1 : b_mag;
    udiv   = b_zero ? 32'd1 : mdu.B;
    mq     = a_mag / sdiv;
    mr     = a_mag % sdiv;
    sq     = (a_neg ^ b_neg) ? (32'd0 - mq) : mq;
    sr     = a_neg ? (32'd0 - mr) : mr;   // remainder follows the dividend
    uq     = mdu.A / udiv;
    ur     = mdu.A % udiv;
  end

`ifdef MDU_MADD_EN
  // Accumulate against the HI/LO committed at issue time.
  logic [63:0] acc_add, acc_sub;
  assign acc_add = {hi_q, lo_q} + prod_s;
  assign acc_sub = {hi_q, lo_q} - prod_s;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;

    case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          case (mdu.MDU_op)
            OP_MULT: begin
              {phi_d, plo_d} = prod_s;
              pwr_d   = 1'b1;
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
            OP_MULTU: begin
              {phi_d, plo_d} = prod_u;
              pwr_d   = 1'b1;
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
            OP_DIV: begin
              phi_d   = sr;
              plo_d   = sq;
              pwr_d   = ~b_zero;
              cnt_d   = DIV_N;
              state_d = S_RUN;
            end
            OP_DIVU: begin
              phi_d   = ur;
              plo_d   = uq;
              pwr_d   = ~b_zero;
              cnt_d   = DIV_N;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = mdu.A;
            OP_MTLO: lo_d = mdu.A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {phi_d, plo_d} = acc_add;
              pwr_d   = 1'b1;
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
            OP_MSUB: begin
              {phi_d, plo_d} = acc_sub;
              pwr_d   = 1'b1;
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end

      S_RUN: begin
        // Starts are ignored here; the hazard unit stalls E instead.
        // <= 1 rather than == 1 so an out-of-range 0 cannot lock the unit.
        if (cnt_q <= 8'd1) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  // busy comes straight from the state flop, so an async reset drops it
  // immediately. HILO_out never sees pending or same-cycle MT values.
  assign mdu.busy     = (state_q == S_RUN);
  assign mdu.HI       = hi_q;
  assign mdu.LO       = lo_q;
  assign mdu.HILO_out = mdu.HILO_sel ? hi_q : lo_q;

endmodule
